// File: rtl/pipe_data_path.sv
// Two-stage datapath: stage 1 reads and selects operands, stage 2 executes and writes back.
// The cpuConfig package holds the ALU function encoding shared with the decoder.
package cpuConfig;
  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_PASS_B = 3'd5,
    ALU_SHL    = 3'd6,
    ALU_SHR    = 3'd7
  } aluFunc_t;
endpackage

module pipe_data_path
  import cpuConfig::*;
#(
  parameter int N       = 8,
  parameter int R_SIZE  = 3,
  parameter int FORWARD = 1
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              inValid,
  input  logic              hold,
  input  logic              writeReg,
  input  aluFunc_t          aluFunc,
  input  logic              aluImmediate,
  input  logic [R_SIZE-1:0] opD,
  input  logic [R_SIZE-1:0] opS,
  input  logic [N-1:0]      opT,
  output logic [N-1:0]      displayResult,
  output logic              resultValid,
  output logic              flagZ,
  output logic              flagN
);
  localparam int R_NUM = 1 << R_SIZE;

  logic [N-1:0]      rf_q [R_NUM];
  logic [N-1:0]      rf_d [R_NUM];
  logic              s1_valid_q, s1_valid_d;
  logic [N-1:0]      s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  aluFunc_t          s1_func_q, s1_func_d;
  logic              s1_write_q, s1_write_d;
  logic [R_SIZE-1:0] s1_dest_q, s1_dest_d;
  logic [N-1:0]      result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              flag_z_q, flag_z_d, flag_n_q, flag_n_d;

  logic [N-1:0] alu_res, file_a, file_b, oper_a, oper_b;
  logic         s2_writes, fwd_a, fwd_b, wb_en;

  always_comb begin
    alu_res = '0;
    case (s1_func_q)
      ALU_ADD:    alu_res = s1_a_q + s1_b_q;
      ALU_SUB:    alu_res = s1_a_q - s1_b_q;
      ALU_AND:    alu_res = s1_a_q & s1_b_q;
      ALU_OR:     alu_res = s1_a_q | s1_b_q;
      ALU_XOR:    alu_res = s1_a_q ^ s1_b_q;
      ALU_PASS_B: alu_res = s1_b_q;
      ALU_SHL:    alu_res = s1_a_q << 1;
      ALU_SHR:    alu_res = s1_a_q >> 1;
      default:    alu_res = '0;
    endcase
  end

  // Register 0 is never written; the explicit mux keeps reads of it zero regardless.
  assign file_a    = (opD == '0) ? '0 : rf_q[opD];
  assign file_b    = (opS == '0) ? '0 : rf_q[opS];
  assign s2_writes = s1_valid_q && s1_write_q && (s1_dest_q != '0);
  assign wb_en     = !hold && s2_writes;
  assign fwd_a     = (FORWARD != 0) && s2_writes && (opD == s1_dest_q);
  assign fwd_b     = (FORWARD != 0) && s2_writes && (opS == s1_dest_q);
  assign oper_a    = fwd_a ? alu_res : file_a;
  assign oper_b    = aluImmediate ? opT : (fwd_b ? alu_res : file_b);

  always_comb begin
    rf_d = rf_q;
    if (wb_en) rf_d[s1_dest_q] = alu_res;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_func_d  = s1_func_q;
    s1_write_d = s1_write_q;
    s1_dest_d  = s1_dest_q;
    if (!hold) begin
      s1_valid_d = inValid;
      if (inValid) begin
        s1_a_d     = oper_a;
        s1_b_d     = oper_b;
        s1_func_d  = aluFunc;
        s1_write_d = writeReg;
        s1_dest_d  = opD;
      end
    end
  end

  always_comb begin
    result_d       = result_q;
    result_valid_d = result_valid_q;
    flag_z_d       = flag_z_q;
    flag_n_d       = flag_n_q;
    if (!hold) begin
      result_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = alu_res;
        flag_z_d = (alu_res == '0);
        flag_n_d = alu_res[N-1];
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < R_NUM; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      s1_valid_q     <= 1'b0;
      s1_a_q         <= '0;
      s1_b_q         <= '0;
      s1_func_q      <= ALU_ADD;
      s1_write_q     <= 1'b0;
      s1_dest_q      <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      flag_z_q       <= 1'b1;
      flag_n_q       <= 1'b0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_a_q         <= s1_a_d;
      s1_b_q         <= s1_b_d;
      s1_func_q      <= s1_func_d;
      s1_write_q     <= s1_write_d;
      s1_dest_q      <= s1_dest_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      flag_z_q       <= flag_z_d;
      flag_n_q       <= flag_n_d;
    end
  end

  assign displayResult = result_q;
  assign resultValid   = result_valid_q;
  assign flagZ         = flag_z_q;
  assign flagN         = flag_n_q;

endmodule

// File: tb/tb_pipe_data_path.sv
// Bench for pipe_data_path: a bypassing and a non-bypassing copy share one stimulus stream,
// each checked against its own architectural model through a result queue.
module tb_pipe_data_path;
  import cpuConfig::*;

  logic       clk = 1'b0;
  logic       nReset = 1'b1;
  logic       inValid = 1'b0, hold = 1'b0, writeReg = 1'b0, aluImmediate = 1'b0;
  aluFunc_t   aluFunc = ALU_ADD;
  logic [2:0] opD = '0, opS = '0;
  logic [7:0] opT = '0;

  logic [7:0] disp_f, disp_nf;
  logic       rv_f, rv_nf, z_f, z_nf, n_f, n_nf;

  pipe_data_path #(.N(8), .R_SIZE(3), .FORWARD(1)) dut_fwd (
    .clk(clk), .nReset(nReset), .inValid(inValid), .hold(hold), .writeReg(writeReg),
    .aluFunc(aluFunc), .aluImmediate(aluImmediate), .opD(opD), .opS(opS), .opT(opT),
    .displayResult(disp_f), .resultValid(rv_f), .flagZ(z_f), .flagN(n_f)
  );

  pipe_data_path #(.N(8), .R_SIZE(3), .FORWARD(0)) dut_nofwd (
    .clk(clk), .nReset(nReset), .inValid(inValid), .hold(hold), .writeReg(writeReg),
    .aluFunc(aluFunc), .aluImmediate(aluImmediate), .opD(opD), .opS(opS), .opT(opT),
    .displayResult(disp_nf), .resultValid(rv_nf), .flagZ(z_nf), .flagN(n_nf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural models: file_f sees every earlier op, file_nf lags by the op still in flight.
  logic [7:0] file_f [8];
  logic [7:0] file_nf [8];
  logic [7:0] q_f [$];
  logic [7:0] q_nf [$];
  logic       pend_v;
  logic [2:0] pend_d;
  logic [7:0] pend_r;
  logic       s1v_m, exp_rv;
  logic [7:0] last_f, last_nf;

  function automatic logic [7:0] alu_m(input aluFunc_t f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      ALU_ADD:    return a + b;
      ALU_SUB:    return a - b;
      ALU_AND:    return a & b;
      ALU_OR:     return a | b;
      ALU_XOR:    return a ^ b;
      ALU_PASS_B: return b;
      ALU_SHL:    return {a[6:0], 1'b0};
      default:    return {1'b0, a[7:1]};
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      file_f[i]  = 8'h00;
      file_nf[i] = 8'h00;
    end
    q_f.delete();
    q_nf.delete();
    pend_v  = 1'b0;
    pend_d  = '0;
    pend_r  = '0;
    s1v_m   = 1'b0;
    exp_rv  = 1'b0;
    last_f  = 8'h00;
    last_nf = 8'h00;
  endtask

  // Advance the models by one active edge using the inputs now on the pins.
  task automatic step();
    logic [7:0] a, b, r, r_nf;
    r_nf   = 8'h00;
    exp_rv = s1v_m;
    s1v_m  = inValid;
    if (inValid) begin
      a = file_f[opD];
      b = aluImmediate ? opT : file_f[opS];
      r = alu_m(aluFunc, a, b);
      q_f.push_back(r);
      if (writeReg && opD != 3'd0) file_f[opD] = r;
      a    = file_nf[opD];
      b    = aluImmediate ? opT : file_nf[opS];
      r_nf = alu_m(aluFunc, a, b);
      q_nf.push_back(r_nf);
    end
    if (pend_v) file_nf[pend_d] = pend_r;
    pend_v = inValid && writeReg && (opD != 3'd0);
    pend_d = opD;
    pend_r = r_nf;
  endtask

  task automatic drive(input logic inv, input logic h, input aluFunc_t f, input logic imm,
                       input logic [2:0] d, input logic [2:0] s, input logic [7:0] t,
                       input logic wr);
    @(negedge clk);
    inValid      = inv;
    hold         = h;
    aluFunc      = f;
    aluImmediate = imm;
    opD          = d;
    opS          = s;
    opT          = t;
    writeReg     = wr;
    if (!h) step();
  endtask

  task automatic op(input aluFunc_t f, input logic imm, input logic [2:0] d,
                    input logic [2:0] s, input logic [7:0] t, input logic wr);
    drive(1'b1, 1'b0, f, imm, d, s, t, wr);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, ALU_ADD, 1'b0, 3'd0, 3'd0, 8'h00, 1'b0);
  endtask

  task automatic reset_chk();
    chk("rst_disp_fwd", disp_f, 0);
    chk("rst_rv_fwd", rv_f, 0);
    chk("rst_z_fwd", z_f, 1);
    chk("rst_n_fwd", n_f, 0);
    chk("rst_disp_nofwd", disp_nf, 0);
    chk("rst_rv_nofwd", rv_nf, 0);
    chk("rst_z_nofwd", z_nf, 1);
    chk("rst_n_nofwd", n_nf, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    nReset   = 1'b1;
    inValid  = 1'b0;
    hold     = 1'b0;
    writeReg = 1'b0;
    step();
  endtask

  logic mon_hold, mon_rst;
  always @(posedge clk) begin
    mon_hold = hold;
    mon_rst  = nReset;
    #1;
    if (mon_rst && nReset) begin
      chk("rv_fwd", rv_f, exp_rv);
      chk("rv_nofwd", rv_nf, exp_rv);
      if (!mon_hold && exp_rv) begin
        chk("sb_ready", 32'((q_f.size() > 0) && (q_nf.size() > 0)), 1);
        if (q_f.size() > 0 && q_nf.size() > 0) begin
          last_f  = q_f.pop_front();
          last_nf = q_nf.pop_front();
        end
      end
      chk("disp_fwd", disp_f, last_f);
      chk("z_fwd", z_f, last_f == 8'h00);
      chk("n_fwd", n_f, last_f[7]);
      chk("disp_nofwd", disp_nf, last_nf);
      chk("z_nofwd", z_nf, last_nf == 8'h00);
      chk("n_nofwd", n_nf, last_nf[7]);
    end
  end

  initial begin
    model_clear();
    #2 nReset = 1'b0;
    #1 reset_chk();
    repeat (2) @(negedge clk);
    release_reset();

    // Back-to-back dependent immediates: 5 then 8 with bypass, 5 then 3 without.
    op(ALU_ADD, 1'b1, 3'd1, 3'd0, 8'd5, 1'b1);
    op(ALU_ADD, 1'b1, 3'd1, 3'd0, 8'd3, 1'b1);
    idle();
    // Same chain spaced by an idle cycle: both builds give 8.
    op(ALU_ADD, 1'b1, 3'd5, 3'd0, 8'd5, 1'b1);
    idle();
    op(ALU_ADD, 1'b1, 3'd5, 3'd0, 8'd3, 1'b1);
    idle();

    // Register 0: the 0x7F write is dropped and never bypassed.
    op(ALU_ADD, 1'b1, 3'd2, 3'd0, 8'd1, 1'b1);
    op(ALU_ADD, 1'b1, 3'd0, 3'd0, 8'h7F, 1'b1);
    op(ALU_ADD, 1'b0, 3'd2, 3'd0, 8'h00, 1'b1);
    idle();

    // Wrap and flags.
    op(ALU_ADD, 1'b1, 3'd3, 3'd0, 8'hFF, 1'b1);
    op(ALU_ADD, 1'b1, 3'd3, 3'd0, 8'h01, 1'b1);
    op(ALU_SUB, 1'b1, 3'd4, 3'd0, 8'h01, 1'b1);
    idle();

    // Hold with an op in stage 1; the ops offered during hold must be ignored.
    op(ALU_ADD, 1'b1, 3'd6, 3'd0, 8'h11, 1'b1);
    repeat (3) drive(1'b1, 1'b1, ALU_XOR, 1'b1, 3'd6, 3'd0, 8'hAA, 1'b1);
    idle();
    idle();
    op(ALU_ADD, 1'b1, 3'd6, 3'd0, 8'h00, 1'b0);
    op(ALU_ADD, 1'b1, 3'd6, 3'd0, 8'h11, 1'b1);
    idle();

    repeat (80) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
            aluFunc_t'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    idle();
    idle();

    // Reset with an op sitting in stage 1: it must vanish without writing r7.
    op(ALU_ADD, 1'b1, 3'd7, 3'd0, 8'h42, 1'b1);
    op(ALU_ADD, 1'b1, 3'd7, 3'd0, 8'h01, 1'b1);
    @(posedge clk);
    #3 nReset = 1'b0;
    #1 reset_chk();
    model_clear();
    @(negedge clk);
    release_reset();
    for (int i = 0; i < 8; i++) op(ALU_ADD, 1'b1, 3'(i), 3'd0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) op(ALU_OR, 1'b0, 3'(i), 3'(7 - i), 8'h00, 1'b0);
    idle();
    idle();

    chk("sb_drained", q_f.size() + q_nf.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
